// File: rtl/serial_word_tx.sv
// serial_word_tx: buffers 16-bit host words in a small FIFO and shifts each
// one out MSB-first on sdo, one bit per data_CLK, marking the MSB with sdo_frame.
//
// Ports:
//   data_CLK, RST        bit clock, asynchronous active-high reset
//   enable               permit starting new words
//   s_data/s_valid/s_ready  host word input (s_ready = buffer not full)
//   clr_ovf              clears the sticky overflow flag
//   sdo, sdo_frame, sdo_en  registered serial outputs
//   busy                 FSM not idle
//   fifo_level           words held in the input buffer
//   words_sent           completed-word counter, wraps at 2^16
//   overflow             sticky: a word was offered while the buffer was full
module serial_word_tx #(
    parameter int   WORD_W     = 16,
    parameter int   FIFO_DEPTH = 4,
    parameter int   GAP_CYCLES = 0,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic                          data_CLK,
    input  logic                          RST,
    input  logic                          enable,
    input  logic [WORD_W-1:0]             s_data,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic                          clr_ovf,
    output logic                          sdo,
    output logic                          sdo_frame,
    output logic                          sdo_en,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [15:0]                   words_sent,
    output logic                          overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(WORD_W);

    localparam logic [LW-1:0] FULL_LVL  = LW'(FIFO_DEPTH);
    localparam logic [CW-1:0] LAST_BIT  = CW'(WORD_W - 1);
    localparam logic [7:0]    GAP_LAST  = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t              state;
    logic [WORD_W-1:0]   shreg;
    logic [CW-1:0]       bit_cnt;
    logic [7:0]          gap_cnt;

    logic [WORD_W-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [LW-1:0]       level;

    logic push;
    logic pop;
    logic start_ok;
    logic last_bit;
    logic gap_done;
    logic [WORD_W-1:0] head;

    // Ready comes from the registered level, so a same-cycle pop never
    // makes room for a push into a full buffer.
    assign s_ready    = (level != FULL_LVL);
    assign fifo_level = level;
    assign busy       = (state != IDLE);

    assign push     = s_valid && s_ready;
    assign head     = mem[rd_ptr];
    assign start_ok = enable && (level != '0);
    assign last_bit = (state == SHIFT) && (bit_cnt == LAST_BIT);
    assign gap_done = (state == GAP) && (gap_cnt == GAP_LAST);

    // A new word is taken from idle, straight after a last bit when no gap
    // is configured, or at the end of the gap.
    always_comb begin
        pop = 1'b0;
        if (start_ok) begin
            if (state == IDLE)
                pop = 1'b1;
            else if (last_bit && (GAP_CYCLES == 0))
                pop = 1'b1;
            else if (gap_done)
                pop = 1'b1;
        end
    end

    always_ff @(posedge data_CLK) begin
        if (push)
            mem[wr_ptr] <= s_data;
    end

    always_ff @(posedge data_CLK or posedge RST) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // A new overflow in the same cycle as clr_ovf keeps the flag set.
    always_ff @(posedge data_CLK or posedge RST) begin
        if (RST)
            overflow <= 1'b0;
        else if (s_valid && !s_ready)
            overflow <= 1'b1;
        else if (clr_ovf)
            overflow <= 1'b0;
    end

    always_ff @(posedge data_CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            sdo        <= IDLE_LEVEL;
            sdo_frame  <= 1'b0;
            sdo_en     <= 1'b0;
            words_sent <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    sdo       <= IDLE_LEVEL;
                    sdo_frame <= 1'b0;
                    sdo_en    <= 1'b0;
                    if (pop) begin
                        shreg   <= head;
                        bit_cnt <= '0;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    sdo       <= shreg[WORD_W-1];
                    sdo_frame <= (bit_cnt == '0);
                    sdo_en    <= 1'b1;
                    shreg     <= shreg << 1;
                    bit_cnt   <= bit_cnt + 1'b1;
                    if (last_bit) begin
                        words_sent <= words_sent + 16'd1;
                        if (GAP_CYCLES > 0) begin
                            gap_cnt <= '0;
                            state   <= GAP;
                        end else if (pop) begin
                            shreg   <= head;
                            bit_cnt <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                GAP: begin
                    sdo       <= IDLE_LEVEL;
                    sdo_frame <= 1'b0;
                    sdo_en    <= 1'b0;
                    if (gap_done) begin
                        if (pop) begin
                            shreg   <= head;
                            bit_cnt <= '0;
                            state   <= SHIFT;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_word_tx.sv
// Bench for serial_word_tx: scoreboard of expected serial bits plus
// table-driven single-word vectors and hand-written multi-cycle sequences.
module tb_serial_word_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [15:0] s_data = '0;
    logic        s_valid = 1'b0;
    logic        clr_ovf = 1'b0;

    logic        rdy0, sdo0, fr0, en0, busy0, ovf0;
    logic [2:0]  lvl0;
    logic [15:0] sent0;
    logic        rdy2, sdo2, fr2, en2, busy2, ovf2;
    logic [2:0]  lvl2;
    logic [15:0] sent2;

    serial_word_tx #(.GAP_CYCLES(0)) dut0 (
        .data_CLK(clk), .RST(rst), .enable(enable),
        .s_data(s_data), .s_valid(s_valid), .s_ready(rdy0),
        .clr_ovf(clr_ovf), .sdo(sdo0), .sdo_frame(fr0), .sdo_en(en0),
        .busy(busy0), .fifo_level(lvl0), .words_sent(sent0),
        .overflow(ovf0)
    );

    serial_word_tx #(.GAP_CYCLES(2)) dut2 (
        .data_CLK(clk), .RST(rst), .enable(enable),
        .s_data(s_data), .s_valid(s_valid), .s_ready(rdy2),
        .clr_ovf(clr_ovf), .sdo(sdo2), .sdo_frame(fr2), .sdo_en(en2),
        .busy(busy2), .fifo_level(lvl2), .words_sent(sent2),
        .overflow(ovf2)
    );

    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;
    logic [1:0] exp_q[$];
    logic [1:0] e;

    typedef struct {
        logic [15:0] w;
        logic [15:0] sent;
    } vec_t;
    vec_t tv[4];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every bit dut0 shifts out is compared to the queued model.
    always @(negedge clk) begin
        if (!rst && en0) begin
            if (exp_q.size() == 0) begin
                check("unexpected_bit", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("sb_sdo", {31'd0, sdo0}, {31'd0, e[1]});
                check("sb_frame", {31'd0, fr0}, {31'd0, e[0]});
            end
        end
    end

    // Called at a negedge; returns at the next negedge with s_valid low.
    task automatic drive(input logic [15:0] w, input logic acc);
        check("s_ready", {31'd0, rdy0}, {31'd0, acc});
        s_data  = w;
        s_valid = 1'b1;
        if (acc)
            for (int i = 15; i >= 0; i--)
                exp_q.push_back({w[i], (i == 15) ? 1'b1 : 1'b0});
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        logic done;
        done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (!busy0 && !en0 && lvl0 == 3'd0) begin
                done = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("wait_idle_timeout", {31'd0, done}, 32'd1);
        check("sb_drained", exp_q.size(), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        tv[0] = '{16'hA5C3, 16'd1};
        tv[1] = '{16'hFFFF, 16'd2};
        tv[2] = '{16'h0001, 16'd3};
        tv[3] = '{16'h8000, 16'd4};

        do_reset();
        check("rst_sdo", {31'd0, sdo0}, 32'd0);
        check("rst_frame", {31'd0, fr0}, 32'd0);
        check("rst_en", {31'd0, en0}, 32'd0);
        check("rst_busy", {31'd0, busy0}, 32'd0);
        check("rst_ready", {31'd0, rdy0}, 32'd1);
        check("rst_level", {29'd0, lvl0}, 32'd0);
        check("rst_sent", {16'd0, sent0}, 32'd0);
        check("rst_ovf", {31'd0, ovf0}, 32'd0);

        // Single words: latency, framing and completion count.
        enable = 1'b1;
        foreach (tv[n]) begin
            drive(tv[n].w, 1'b1);
            check("lat_k", {31'd0, en0}, 32'd0);
            @(negedge clk);
            check("lat_k1_en", {31'd0, en0}, 32'd0);
            check("lat_k1_busy", {31'd0, busy0}, 32'd1);
            @(negedge clk);
            check("lat_k2_en", {31'd0, en0}, 32'd1);
            check("lat_k2_frame", {31'd0, fr0}, 32'd1);
            check("lat_k2_msb", {31'd0, sdo0}, {31'd0, tv[n].w[15]});
            repeat (15) @(negedge clk);
            check("last_en", {31'd0, en0}, 32'd1);
            check("last_sent", {16'd0, sent0}, {16'd0, tv[n].sent});
            @(negedge clk);
            check("after_en", {31'd0, en0}, 32'd0);
            check("after_busy", {31'd0, busy0}, 32'd0);
        end

        // Back-to-back words with no gap.
        drive(16'h1234, 1'b1);
        drive(16'hBEEF, 1'b1);
        drive(16'h0F0F, 1'b1);
        for (int i = 0; i < 48; i++) begin
            check("b2b_en", {31'd0, en0}, 32'd1);
            check("b2b_frame", {31'd0, fr0},
                  {31'd0, (i % 16 == 0) ? 1'b1 : 1'b0});
            @(negedge clk);
        end
        check("b2b_end_en", {31'd0, en0}, 32'd0);
        check("b2b_sent", {16'd0, sent0}, 32'd7);

        // Fill while disabled, overflow, drain, clear.
        enable = 1'b0;
        drive(16'h1111, 1'b1);
        drive(16'h2222, 1'b1);
        drive(16'h3333, 1'b1);
        drive(16'h4444, 1'b1);
        check("full_level", {29'd0, lvl0}, 32'd4);
        drive(16'hDEAD, 1'b0);
        check("ovf_set", {31'd0, ovf0}, 32'd1);
        check("ovf_level", {29'd0, lvl0}, 32'd4);
        check("ovf_idle", {31'd0, en0}, 32'd0);
        enable = 1'b1;
        wait_idle(200);
        check("drain_sent", {16'd0, sent0}, 32'd11);
        check("ovf_held", {31'd0, ovf0}, 32'd1);
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        check("ovf_clr", {31'd0, ovf0}, 32'd0);

        // New overflow in the same cycle as clr_ovf keeps the flag set.
        enable = 1'b0;
        drive(16'h5555, 1'b1);
        drive(16'h6666, 1'b1);
        drive(16'h7777, 1'b1);
        drive(16'h8888, 1'b1);
        clr_ovf = 1'b1;
        drive(16'hBAD0, 1'b0);
        clr_ovf = 1'b0;
        check("ovf_wins", {31'd0, ovf0}, 32'd1);
        enable = 1'b1;
        wait_idle(200);
        check("drain2_sent", {16'd0, sent0}, 32'd15);
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;

        // enable drops mid-word with a second word queued.
        drive(16'hC001, 1'b1);
        drive(16'hD00D, 1'b1);
        repeat (6) @(negedge clk);
        check("mid_en", {31'd0, en0}, 32'd1);
        enable = 1'b0;
        repeat (12) @(negedge clk);
        check("hold_en", {31'd0, en0}, 32'd0);
        check("hold_busy", {31'd0, busy0}, 32'd0);
        check("hold_level", {29'd0, lvl0}, 32'd1);
        check("hold_sent", {16'd0, sent0}, 32'd16);
        enable = 1'b1;
        wait_idle(100);
        check("resume_sent", {16'd0, sent0}, 32'd17);

        // Two-cycle inter-word gap on the GAP_CYCLES=2 instance.
        do_reset();
        drive(16'hF00F, 1'b1);
        drive(16'h7E81, 1'b1);
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            check("gap_w1_en", {31'd0, en2}, 32'd1);
            @(negedge clk);
        end
        for (int i = 0; i < 2; i++) begin
            check("gap_en", {31'd0, en2}, 32'd0);
            check("gap_sdo", {31'd0, sdo2}, 32'd0);
            @(negedge clk);
        end
        check("gap_w2_en", {31'd0, en2}, 32'd1);
        check("gap_w2_frame", {31'd0, fr2}, 32'd1);
        check("gap_w2_msb", {31'd0, sdo2}, 32'd0);
        repeat (20) @(negedge clk);
        check("gap_sent", {16'd0, sent2}, 32'd2);
        wait_idle(50);
        check("gap_sent0", {16'd0, sent0}, 32'd2);

        // Reset in the middle of a word.
        drive(16'hFFFF, 1'b1);
        repeat (10) @(negedge clk);
        check("pre_rst_en", {31'd0, en0}, 32'd1);
        check("pre_rst_sent", {16'd0, sent0}, 32'd2);
        #2;
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("arst_sdo", {31'd0, sdo0}, 32'd0);
        check("arst_en", {31'd0, en0}, 32'd0);
        check("arst_frame", {31'd0, fr0}, 32'd0);
        check("arst_level", {29'd0, lvl0}, 32'd0);
        check("arst_sent", {16'd0, sent0}, 32'd0);
        check("arst_busy", {31'd0, busy0}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        drive(16'h3C5A, 1'b1);
        @(negedge clk);
        @(negedge clk);
        check("post_frame", {31'd0, fr0}, 32'd1);
        wait_idle(40);
        check("post_sent", {16'd0, sent0}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
